// File: rtl/learn_step_controller_if.sv
// Shared element type and the sample/layer/result bus bundle
// for the learn-step controller.
package learn_step_pkg;
  typedef logic [7:0] zero2one_t;
endpackage

interface learn_step_controller_if #(
  parameter int N = 16,
  parameter int M = 51
);
  import learn_step_pkg::*;

  logic                  s_valid;
  logic                  s_ready;
  zero2one_t [N-1:0]     s_in;
  zero2one_t [M-1:0]     s_expected;
  logic                  s_learn;

  logic                  lay_valid;
  logic                  lay_learn;
  zero2one_t [N-1:0]     lay_in;
  zero2one_t [M-1:0]     lay_expected_out;
  zero2one_t [M-1:0]     lay_out;
  zero2one_t [N-1:0]     lay_expected_in;

  logic                  m_valid;
  logic                  m_ready;
  zero2one_t [M-1:0]     m_out;
  zero2one_t [N-1:0]     m_expected_in;

  modport master (
    input  s_valid, s_in, s_expected, s_learn,
    output s_ready,
    output lay_valid, lay_learn,
    output lay_in, lay_expected_out,
    input  lay_out, lay_expected_in,
    output m_valid, m_out, m_expected_in,
    input  m_ready
  );

  modport slave (
    output s_valid, s_in, s_expected, s_learn,
    input  s_ready,
    input  lay_valid, lay_learn,
    input  lay_in, lay_expected_out,
    output lay_out, lay_expected_in,
    input  m_valid, m_out, m_expected_in,
    output m_ready
  );
endinterface

// File: rtl/learn_step_controller.sv
// Sequences one sample through a layer: settle, optional learn, respond.
// LEARN_STEP_STATS_EN adds a saturating sample_count output.
module learn_step_controller
  import learn_step_pkg::*;
#(
  parameter int N      = 16,
  parameter int M      = 51,
  parameter int SETTLE = 4
) (
  input  logic                    clock,
  input  logic                    rst_n,
  learn_step_controller_if.master bus,
  output logic                    busy
`ifdef LEARN_STEP_STATS_EN
  ,
  output logic [15:0]             sample_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    LEARN = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              learn_q;
  zero2one_t [N-1:0] lay_in_q;
  zero2one_t [M-1:0] lay_exp_q;
  zero2one_t [M-1:0] m_out_q;
  zero2one_t [N-1:0] m_ein_q;

  logic accept;
  logic fwd_last;
  logic cap_ein;
  logic hs;

  assign accept   = (state_q == IDLE) && bus.s_valid;
  assign fwd_last = (state_q == FWD) && (cnt_q == 8'd0);
  assign cap_ein  = (fwd_last && !learn_q) || (state_q == LEARN);
  assign hs       = (state_q == RESP) && bus.m_ready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.s_valid) begin
          state_d = FWD;
          cnt_d   = 8'(SETTLE - 1);
        end
      end
      FWD: begin
        if (cnt_q == 8'd0) begin
          state_d = learn_q ? LEARN : RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      LEARN: state_d = RESP;
      RESP: begin
        if (bus.m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.s_ready   = 1'b0;
    bus.lay_valid = 1'b0;
    bus.lay_learn = 1'b0;
    bus.m_valid   = 1'b0;
    busy          = 1'b1;
    unique case (state_q)
      IDLE: begin
        bus.s_ready = 1'b1;
        busy        = 1'b0;
      end
      FWD:  bus.lay_valid = 1'b1;
      LEARN: begin
        bus.lay_valid = 1'b1;
        bus.lay_learn = 1'b1;
      end
      RESP: bus.m_valid = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  // Layer operands stay put until the next sample is taken
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      learn_q   <= 1'b0;
      lay_in_q  <= '0;
      lay_exp_q <= '0;
    end else if (accept) begin
      learn_q   <= bus.s_learn;
      lay_in_q  <= bus.s_in;
      lay_exp_q <= bus.s_expected;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_out_q <= '0;
      m_ein_q <= '0;
    end else begin
      if (fwd_last) m_out_q <= bus.lay_out;
      if (cap_ein)  m_ein_q <= bus.lay_expected_in;
    end
  end

  assign bus.lay_in           = lay_in_q;
  assign bus.lay_expected_out = lay_exp_q;
  assign bus.m_out            = m_out_q;
  assign bus.m_expected_in    = m_ein_q;

`ifdef LEARN_STEP_STATS_EN
  logic [15:0] sample_cnt_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= 16'd0;
    end else if (hs && (sample_cnt_q != 16'hFFFF)) begin
      sample_cnt_q <= sample_cnt_q + 16'd1;
    end
  end

  assign sample_count = sample_cnt_q;
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_learn_step_controller.sv
// Scoreboard bench for learn_step_controller with a toy layer model.
// Latency counts the acceptance edge as edge 1.
module tb_learn_step_controller;
  import learn_step_pkg::*;

  localparam int N      = 16;
  localparam int M      = 51;
  localparam int SETTLE = 4;

  typedef struct {
    zero2one_t [M-1:0] out;
    zero2one_t [N-1:0] ein;
    zero2one_t [N-1:0] in;
    int                lat;
    int                nv;
    int                nl;
  } exp_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
`ifdef LEARN_STEP_STATS_EN
  logic [15:0] sample_count;
`endif

  always #5 clock = ~clock;

  learn_step_controller_if #(.N(N), .M(M)) bus ();

  learn_step_controller #(
    .N(N), .M(M), .SETTLE(SETTLE)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
`ifdef LEARN_STEP_STATS_EN
    ,
    .sample_count(sample_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hs_cnt = 0;

  exp_t sb[$];
  int   acc_q[$];

  logic [7:0] vcnt;
  int         nv, nl;
  logic       prev_learn;
  bit         in_resp = 0;
  bit         post_hs = 0;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Toy layer: results depend on operands, valid-cycle count and learn
  always_comb begin
    bus.lay_out         = '0;
    bus.lay_expected_in = '0;
    for (int j = 0; j < M; j++)
      bus.lay_out[j] = bus.lay_in[j % N] + vcnt;
    for (int i = 0; i < N; i++)
      bus.lay_expected_in[i] = bus.lay_in[i] + bus.lay_expected_out[i]
                             + vcnt + (bus.lay_learn ? 8'h40 : 8'h00);
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vcnt       <= 8'd0;
      nv         <= 0;
      nl         <= 0;
      prev_learn <= 1'b0;
    end else begin
      if (bus.lay_learn) begin
        chk("learn_once", {prev_learn, ~bus.lay_valid}, 2'b00);
      end
      prev_learn <= bus.lay_learn;
      if (bus.s_valid && bus.s_ready) begin
        acc_q.push_back(cyc + 1);
        vcnt <= 8'd0;
        nv   <= 0;
        nl   <= 0;
      end else begin
        if (bus.lay_valid) vcnt <= vcnt + 8'd1;
        nv <= nv + int'(bus.lay_valid);
        nl <= nl + int'(bus.lay_learn);
      end
    end
  end

  // Monitor
  always @(negedge clock) begin
    exp_t e;
    if (rst_n) begin
      if (post_hs) begin
        chk("ready_after_hs", bus.s_ready, 1'b1);
        post_hs = 0;
      end
      if (bus.m_valid) begin
        chk("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb[0];
          if (!in_resp) begin
            in_resp = 1;
            chk("acc_rec", acc_q.size() != 0, 1'b1);
            if (acc_q.size() != 0)
              chk("latency", cyc - acc_q.pop_front() + 1, e.lat);
            chk("lay_valid_cycles", nv, e.nv);
            chk("lay_learn_cycles", nl, e.nl);
            chk("lay_in_held", bus.lay_in, e.in);
          end
          chk("m_out", bus.m_out, e.out);
          chk("m_expected_in", bus.m_expected_in, e.ein);
          chk("s_ready_in_resp", bus.s_ready, 1'b0);
          if (bus.m_ready) begin
            void'(sb.pop_front());
            hs_cnt++;
            in_resp = 0;
            post_hs = 1;
          end
        end
      end
    end
  end

  function automatic zero2one_t [N-1:0] gen_in(input int s);
    for (int i = 0; i < N; i++) gen_in[i] = 8'(s * 37 + i * 11);
  endfunction

  function automatic zero2one_t [M-1:0] gen_ex(input int s);
    for (int j = 0; j < M; j++) gen_ex[j] = 8'(s * 53 + j * 7 + 200);
  endfunction

  function automatic exp_t model(input int s, input bit learn);
    exp_t              e;
    zero2one_t [N-1:0] in;
    zero2one_t [M-1:0] ex;
    in = gen_in(s);
    ex = gen_ex(s);
    for (int j = 0; j < M; j++) e.out[j] = in[j % N] + 8'(SETTLE - 1);
    for (int i = 0; i < N; i++)
      e.ein[i] = in[i] + ex[i]
               + (learn ? 8'(SETTLE) + 8'h40 : 8'(SETTLE - 1));
    e.in  = in;
    e.lat = SETTLE + 1 + int'(learn);
    e.nv  = SETTLE + int'(learn);
    e.nl  = int'(learn);
    return e;
  endfunction

  // Call at a posedge+1 or negedge point
  task automatic send(input int s, input bit learn, input bit keep);
    bit done = 0;
    bus.s_in       = gen_in(s);
    bus.s_expected = gen_ex(s);
    bus.s_learn    = learn;
    bus.s_valid    = 1'b1;
    sb.push_back(model(s, learn));
    for (int k = 0; k < 200 && !done; k++) begin
      done = bus.s_ready;
      @(posedge clock);
      #1;
    end
    if (!done) chk("accept_timeout", 1'b1, 1'b0);
    if (!keep) bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(posedge clock);
      #1;
      k++;
    end
    if (sb.size() != 0) chk("drain_timeout", 1'b1, 1'b0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int rel, hs0, k;
    bus.s_valid    = 1'b0;
    bus.s_learn    = 1'b0;
    bus.s_in       = '0;
    bus.s_expected = '0;
    bus.m_ready    = 1'b1;

    #2;
    chk("rst_lay_valid", bus.lay_valid, 1'b0);
    chk("rst_lay_learn", bus.lay_learn, 1'b0);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_vectors", {bus.m_out, bus.m_expected_in}, '0);
    chk("rst_lay_vec", {bus.lay_in, bus.lay_expected_out}, '0);
`ifdef LEARN_STEP_STATS_EN
    chk("rst_count", sample_count, 16'd0);
`endif
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    chk("ready_after_rst", bus.s_ready, 1'b1);

    // Plain forward pass, then one with learning
    send(1, 1'b0, 1'b0);
    drain();
    chk("idle_after_fwd", busy, 1'b0);
    send(2, 1'b1, 1'b0);
    drain();
    send(10, 1'b0, 1'b0);
    drain();

    // Downstream stall for 10 RESP cycles
    bus.m_ready = 1'b0;
    send(3, 1'b1, 1'b0);
    k = 0;
    while (!bus.m_valid && k < 50) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk("stall_mvalid", bus.m_valid, 1'b1);
    repeat (10) begin
      @(posedge clock);
      #1;
    end
    chk("stall_hold", {bus.m_valid, bus.s_ready}, 2'b10);
    bus.m_ready = 1'b1;
    drain();

    // Continuous s_valid: each sample taken once, only after handshake
    hs0 = hs_cnt;
    send(4, 1'b0, 1'b1);
    send(5, 1'b1, 1'b1);
    send(6, 1'b0, 1'b1);
    send(7, 1'b1, 1'b0);
    drain();
    chk("b2b_count", hs_cnt - hs0, 4);

    // Reset in the middle of LEARN
    send(8, 1'b1, 1'b0);
    k = 0;
    while (!bus.lay_learn && k < 50) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk("saw_learn", bus.lay_learn, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_learn", {bus.lay_learn, bus.lay_valid}, 2'b00);
    chk("abort_mvalid", {bus.m_valid, busy}, 2'b00);
    sb.delete();
    acc_q.delete();
    in_resp = 0;
    post_hs = 0;
    @(negedge clock);
    rst_n = 1'b1;
    rel = cyc;
    send(9, 1'b0, 1'b0);
    chk("accept_after_rst", cyc - rel, 1);
    chk("busy_after_acc", busy, 1'b1);
    drain();

`ifdef LEARN_STEP_STATS_EN
    dut.sample_cnt_q = 16'hFFFD;
    #1;
    send(11, 1'b0, 1'b0);
    drain();
    chk("count_fffe", sample_count, 16'hFFFE);
    send(12, 1'b1, 1'b0);
    drain();
    chk("count_ffff", sample_count, 16'hFFFF);
    send(13, 1'b0, 1'b0);
    drain();
    chk("count_sat", sample_count, 16'hFFFF);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/learn_step_controller.md
LEARN_STEP_CONTROLLER -- requirements
Module: learn_step_controller

Interface
REQ-001 SHALL have parameter N, default 16: number of layer inputs.
REQ-002 SHALL have parameter M, default 51: number of neurons in the layer.
REQ-003 SHALL have parameter SETTLE, default 4: number of forward-evaluation cycles before the result is captured; legal range 1..255.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port s_valid, input, 1 bit: upstream sample valid.
REQ-007 SHALL have port s_ready, output, 1 bit: controller can accept a sample.
REQ-008 SHALL have port s_in, input, N x zero2one_t: sample input vector.
REQ-009 SHALL have port s_expected, input, M x zero2one_t: target output vector.
REQ-010 SHALL have port s_learn, input, 1 bit: the sample trains the layer.
REQ-011 SHALL have port lay_valid, output, 1 bit: drives the layer valid input.
REQ-012 SHALL have port lay_learn, output, 1 bit: drives the layer learn input.
REQ-013 SHALL have port lay_in, output, N x zero2one_t: drives the layer in input.
REQ-014 SHALL have port lay_expected_out, output, M x zero2one_t: drives the layer expected_out input.
REQ-015 SHALL have port lay_out, input, M x zero2one_t: layer out result.
REQ-016 SHALL have port lay_expected_in, input, N x zero2one_t: layer averaged backward result.
REQ-017 SHALL have port m_valid, output, 1 bit: result valid to downstream.
REQ-018 SHALL have port m_ready, input, 1 bit: downstream accepts the result.
REQ-019 SHALL have port m_out, output, M x zero2one_t: captured forward result.
REQ-020 SHALL have port m_expected_in, output, N x zero2one_t: captured backward result for the previous layer.
REQ-021 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-022 SHALL implement the FSM IDLE -> FWD -> (LEARN if the latched s_learn is 1) -> RESP -> IDLE.
REQ-023 SHALL drive s_ready=1 only in IDLE; a sample is accepted on an edge where s_valid&&s_ready, and that edge loads s_in, s_expected and s_learn into lay_in, lay_expected_out and a learn latch, then enters FWD.
REQ-024 SHALL hold lay_in and lay_expected_out stable from acceptance until the next acceptance.
REQ-025 SHALL, in FWD, drive lay_valid=1 and lay_learn=0 for exactly SETTLE cycles, timed by a down-counter loaded with SETTLE-1.
REQ-026 SHALL, on the last FWD cycle, capture lay_out into m_out.
REQ-027 SHALL capture lay_expected_in into m_expected_in on the last FWD cycle when the learn latch is 0.
REQ-028 SHALL, in LEARN, drive lay_valid=1 and lay_learn=1 for exactly one cycle, capture lay_expected_in into m_expected_in, and then enter RESP.
REQ-029 SHALL, in RESP, hold m_valid=1 with m_out and m_expected_in stable until m_valid&&m_ready, then return to IDLE; m_valid deasserts on that edge.
REQ-030 SHALL accept a new sample no earlier than the edge after the RESP handshake; m_ready asserted outside RESP SHALL be ignored.
REQ-031 SHALL deliver first m_valid SETTLE+1 edges after acceptance when s_learn=0, and SETTLE+2 edges after acceptance when s_learn=1.
REQ-032 SHALL drive lay_learn only in the LEARN state and never for more than one consecutive cycle.

Reset
REQ-033 SHALL, while rst_n=0, immediately force state IDLE, counter 0, learn latch 0, s_ready=1 after release, lay_valid=0, lay_learn=0, m_valid=0, busy=0, and all vector outputs to 0.
REQ-034 SHALL, when reset is asserted mid-FWD, mid-LEARN or mid-RESP, abort the transaction with no result delivered, and SHALL accept a sample on the first edge after release.

Configuration
REQ-035 SHALL, with LEARN_STEP_STATS_EN defined, add output sample_count (16 bits): incremented on each RESP handshake, saturating at 65535, and reset to 0.
REQ-036 SHALL, without LEARN_STEP_STATS_EN, omit the sample_count port and its logic entirely.

Verification
REQ-037 Bench SHALL cover: SETTLE=4, s_learn=0, m_ready=1 -> lay_valid high for 4 cycles, lay_learn never high, m_valid at edge +5, then IDLE.
REQ-038 Bench SHALL cover: SETTLE=4, s_learn=1 -> lay_learn high for exactly 1 cycle after 4 FWD cycles, m_valid at edge +6, m_expected_in equal to lay_expected_in sampled in LEARN.
REQ-039 Bench SHALL cover: m_ready held 0 for 10 cycles in RESP -> m_valid, m_out and m_expected_in stable, s_ready=0; the handshake on cycle 11 -> s_ready=1 the next cycle.
REQ-040 Bench SHALL cover: s_valid held high continuously -> back-to-back samples each accepted only after the prior RESP handshake, with no sample lost or duplicated.
REQ-041 Bench SHALL cover: rst_n pulsed low during LEARN -> lay_learn=0 immediately, no m_valid, and a new sample accepted on the first edge after release.
REQ-042 Bench SHALL cover: with LEARN_STEP_STATS_EN, sample_count preloaded near 65535 and 3 handshakes -> sample_count stays at 65535.
